// File: rtl/ifft_4_stream.sv
// Streaming 4-point inverse FFT: buffers one frame of 4 bins, runs two registered
// radix-2 butterfly stages, then returns x[0..3] in natural order scaled by 1/4.
module ifft_4_stream #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  out_last
);

  localparam int AW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {LOAD, STAGE1, STAGE2, UNLOAD} state_t;

  state_t                  r_state, w_state_next;
  logic [DATA_WIDTH-1:0]   r_xr [4];
  logic [DATA_WIDTH-1:0]   r_xi [4];
  logic signed [AW-1:0]    r_ar [4];
  logic signed [AW-1:0]    r_ai [4];
  logic [DATA_WIDTH-1:0]   r_sr [4];
  logic [DATA_WIDTH-1:0]   r_si [4];
  logic [1:0]              r_k, r_n;
  logic                    r_in_ready, r_out_valid, r_out_last;
  logic [DATA_WIDTH-1:0]   r_out_r, r_out_i;

  logic                    w_in_fire, w_out_fire;
  logic signed [AW-1:0]    w_er [4];
  logic signed [AW-1:0]    w_ei [4];
  logic signed [AW-1:0]    w_yr [4];
  logic signed [AW-1:0]    w_yi [4];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_er[i] = {{2{r_xr[i][DATA_WIDTH-1]}}, r_xr[i]};
      w_ei[i] = {{2{r_xi[i][DATA_WIDTH-1]}}, r_xi[i]};
    end
  end

  // Second butterfly stage; odd outputs use the +j twiddle of the inverse transform.
  always_comb begin
    w_yr[0] = r_ar[0] + r_ar[2];
    w_yi[0] = r_ai[0] + r_ai[2];
    w_yr[2] = r_ar[0] - r_ar[2];
    w_yi[2] = r_ai[0] - r_ai[2];
    w_yr[1] = r_ar[1] - r_ai[3];
    w_yi[1] = r_ai[1] + r_ar[3];
    w_yr[3] = r_ar[1] + r_ai[3];
    w_yi[3] = r_ai[1] - r_ar[3];
  end

  always_comb begin
    w_in_fire    = (r_state == LOAD) && r_in_ready && in_valid;
    w_out_fire   = (r_state == UNLOAD) && r_out_valid && out_ready;
    w_state_next = r_state;
    case (r_state)
      LOAD:    if (w_in_fire && (r_k == 2'd3)) w_state_next = STAGE1;
      STAGE1:  w_state_next = STAGE2;
      STAGE2:  w_state_next = UNLOAD;
      UNLOAD:  if (w_out_fire && (r_n == 2'd3)) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_xr[i] <= '0;
        r_xi[i] <= '0;
        r_ar[i] <= '0;
        r_ai[i] <= '0;
        r_sr[i] <= '0;
        r_si[i] <= '0;
      end
      r_k         <= '0;
      r_n         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
    end else begin
      r_in_ready <= (w_state_next == LOAD);
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            r_xr[r_k] <= in_r;
            r_xi[r_k] <= in_i;
            r_k       <= r_k + 2'd1;
          end
        end
        STAGE1: begin
          r_ar[0] <= w_er[0] + w_er[2];
          r_ai[0] <= w_ei[0] + w_ei[2];
          r_ar[1] <= w_er[0] - w_er[2];
          r_ai[1] <= w_ei[0] - w_ei[2];
          r_ar[2] <= w_er[1] + w_er[3];
          r_ai[2] <= w_ei[1] + w_ei[3];
          r_ar[3] <= w_er[1] - w_er[3];
          r_ai[3] <= w_ei[1] - w_ei[3];
        end
        STAGE2: begin
          for (int unsigned i = 0; i < 4; i++) begin
            r_sr[i] <= DATA_WIDTH'(w_yr[i] >>> 2);
            r_si[i] <= DATA_WIDTH'(w_yi[i] >>> 2);
          end
        end
        UNLOAD: begin
          // First UNLOAD cycle only primes the output register with x[0].
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_n         <= '0;
            r_out_r     <= r_sr[0];
            r_out_i     <= r_si[0];
          end else if (w_out_fire) begin
            if (r_n == 2'd3) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_n         <= '0;
              r_out_r     <= '0;
              r_out_i     <= '0;
            end else begin
              r_n        <= r_n + 2'd1;
              r_out_last <= (r_n == 2'd2);
              r_out_r    <= r_sr[r_n + 2'd1];
              r_out_i    <= r_si[r_n + 2'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;

endmodule

// File: doc/ifft_4_stream.md
Name: ifft_4_stream

Overview:
- Streaming 4-point inverse FFT; the inverse-direction counterpart of the fft_2 butterfly used in the FFT datapath.
- Accepts one frequency-domain frame of 4 complex bins serially over a valid/ready handshake and buffers it.
- Computes the radix-2 DIT inverse transform in two registered butterfly stages.
- Returns the 4 time-domain samples serially in natural order, scaled by 1/4.

Parameters:
- DATA_WIDTH, 64, width of each real/imaginary component; two's complement signed.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input bin valid.
- in_ready  output  1  block accepts an input bin this cycle.
- in_r  input  DATA_WIDTH  real part of bin X[k].
- in_i  input  DATA_WIDTH  imaginary part of bin X[k].
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts a sample.
- out_r  output  DATA_WIDTH  real part of sample x[n].
- out_i  output  DATA_WIDTH  imaginary part of sample x[n].
- out_last  output  1  high with x[3], the final sample of a frame.

Behaviour:
- Reset (async assert, any state):
  - state=LOAD; in/out counters=0.
  - in_ready=0, out_valid=0, out_last=0, out_r=0, out_i=0.
  - Buffers cleared.
  - in_ready rises on the first rising clk edge after rst deasserts.
- Handshakes:
  - A transfer occurs on a rising edge where valid&&ready.
  - Upstream holds data stable while in_valid && !in_ready; the same rule applies downstream.
- FSM LOAD:
  - in_ready=1.
  - Each input transfer writes buffer[k], with k = 0..3 in arrival order; k increments.
  - The transfer with k=3 moves the FSM to STAGE1 and drops in_ready on the next cycle.
- FSM STAGE1 (1 cycle), computed in DATA_WIDTH+2 signed:
  - a0=X0+X2
  - a1=X0-X2
  - a2=X1+X3
  - a3=X1-X3
  - Then go to STAGE2.
- FSM STAGE2 (1 cycle), using the +j twiddle for the inverse transform:
  - y0=a0+a2
  - y2=a0-a2
  - y1_r=a1_r-a3_i, y1_i=a1_i+a3_r
  - y3_r=a1_r+a3_i, y3_i=a1_i-a3_r
  - Then go to UNLOAD.
- Scaling: x[n]=y[n]>>>2 (arithmetic shift, floor toward -inf), taken as the low DATA_WIDTH bits. No overflow is possible because the internal width is DATA_WIDTH+2.
- FSM UNLOAD:
  - out_valid=1; presents x[n] for n=0..3.
  - n advances only on an output transfer.
  - out_last=1 exactly while n=3.
  - The transfer with n=3 returns the FSM to LOAD. Next cycle: out_valid=0 and in_ready=1.
- Latency: the 4th input transfer at edge T makes out_valid=1 with x[0] after edge T+3 (STAGE1 at T+1, STAGE2 at T+2, outputs registered at T+3).
- in_ready=0 in STAGE1, STAGE2 and UNLOAD. No overlap of frames.
- Back-pressure:
  - out_ready low holds out_r, out_i, out_last and n unchanged indefinitely.
  - out_valid never drops before the transfer completes.
- Idle/bubbles: gaps in in_valid during LOAD are permitted. The partial-frame count is held and no timeout applies.
- Reset mid-frame, in any state: the partial frame and pending outputs are discarded. The next frame starts at k=0.

Test Plan:
- Impulse at DC: X=(4,0),(0,0),(0,0),(0,0) with out_ready=1 → x=(1,0) ×4, out_last only on the 4th sample; first out_valid 3 cycles after the 4th input transfer.
- Single tone: X1=(4,0), other bins 0 → x=(1,0),(0,1),(-1,0),(0,-1).
- Flat spectrum: all bins (4,0) → x=(4,0),(0,0),(0,0),(0,0).
- Rounding/sign: X0=(-1,3), others 0 → every x=(-1,0).
  - Real: -1>>>2=-1.
  - Imaginary: 3>>>2=0.
- Extremes, DATA_WIDTH=8: all bins (127,-128) → x0=(127,-128), x1..x3=(0,0). Confirms no wrap.
- Handshake stress:
  - Random in_valid gaps and random out_ready stalls over 3 back-to-back frames; outputs held stable while stalled.
  - in_ready=0 from STAGE1 until the last output transfer.
  - Then rst pulsed after 2 inputs of a 4th frame → all outputs 0 immediately; next full frame produces correct results.
